// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and buffers them
// with their PCs in a small FIFO that feeds the decoder through valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       target_q, target_d;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]       data_mem [BUF_DEPTH];
  logic [31:0]       pc_mem   [BUF_DEPTH];
  logic [31:0]       held_inst_q, held_pc_q;

  logic [31:0] redirect_tgt;
  logic        flush, push, pop;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign flush        = redirect && (state_q != StIdle);
  assign push         = (state_q == StFetch) && imem_req && imem_ack && !redirect;
  assign pop          = inst_valid && inst_ready && !flush;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (redirect) begin
          // A raised request must be drained before the new target can be fetched.
          if (imem_req && !imem_ack) begin
            state_d  = StDrain;
            target_d = redirect_tgt;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (push) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StDrain: begin
        if (redirect) target_d = redirect_tgt;
        if (imem_ack) begin
          state_d = StFetch;
          pc_d    = redirect ? redirect_tgt : target_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req   = ((state_q == StFetch) && (count_q < CntW'(BUF_DEPTH))) || (state_q == StDrain);
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    inst       = inst_valid ? data_mem[rd_ptr_q] : held_inst_q;
    inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : held_pc_q;
  end

  // Instruction FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      held_inst_q <= '0;
      held_pc_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      // Remember the presented head so an empty FIFO keeps showing it.
      if (inst_valid) begin
        held_inst_q <= data_mem[rd_ptr_q];
        held_pc_q   <= pc_mem[rd_ptr_q];
      end
      if (flush) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          data_mem[wr_ptr_q] <= imem_rdata;
          pc_mem[wr_ptr_q]   <= pc_q;
          wr_ptr_q           <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic        req2, valid2;
  logic [31:0] addr2, inst2, inst_pc2;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(Depth)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(Depth)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(valid2), .inst(inst2),
    .inst_pc(inst_pc2), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: started flag, draining flag, PC, pending target, FIFO as queues.
  bit          m_started, m_drain;
  logic [31:0] m_pc, m_target;
  logic [31:0] q_pc[$], q_data[$];

  function automatic bit m_req();
    return m_started && (m_drain || (q_pc.size() < Depth));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 1'b0;
      m_drain   = 1'b0;
      m_pc      = 32'h0;
      m_target  = 32'h0;
      q_pc.delete();
      q_data.delete();
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      logic [31:0] tgt;
      bit          req;
      tgt = redirect_pc & 32'hFFFF_FFFC;
      req = m_req();
      if (redirect) begin
        q_pc.delete();
        q_data.delete();
        if (m_drain) begin
          if (imem_ack) begin m_pc = tgt; m_drain = 1'b0; end
          else m_target = tgt;
        end else if (req && !imem_ack) begin
          m_drain  = 1'b1;
          m_target = tgt;
        end else begin
          m_pc = tgt;
        end
      end else if (m_drain) begin
        if (imem_ack) begin m_pc = m_target; m_drain = 1'b0; end
      end else begin
        if (q_pc.size() > 0 && inst_ready) begin
          void'(q_pc.pop_front());
          void'(q_data.pop_front());
        end
        if (req && imem_ack) begin
          q_pc.push_back(m_pc);
          q_data.push_back(imem_rdata);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("req", {31'b0, imem_req}, {31'b0, m_req()});
      check("addr", imem_addr, m_pc);
      check("valid", {31'b0, inst_valid}, {31'b0, q_pc.size() > 0});
      if (q_pc.size() > 0) begin
        check("inst", inst, q_data[0]);
        check("inst_pc", inst_pc, q_pc[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = $urandom;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_addr_wrap", addr2, 32'hFFFF_FFFC);

    // Back-to-back fetch with same-cycle acks
    tick(); rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
    tick(); @(negedge clk);
    check("t1_req", {31'b0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t5_addr_wrap0", addr2, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_valid", {31'b0, inst_valid}, 32'd1);
    check("t1_pc0", inst_pc, 32'h0);
    check("t5_addr_wrap1", addr2, 32'h0);
    tick(); @(negedge clk);
    check("t1_addr8", imem_addr, 32'h8);
    check("t1_pc4", inst_pc, 32'h4);

    // Decoder stalls: FIFO fills and the request drops
    inst_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t2_req_drop", {31'b0, imem_req}, 32'd0);
    check("t2_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    tick(); imem_ack = 1'b0;
    tick(); tick();

    // Redirect while a request is outstanding; ack arrives 3 clocks later
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick(); redirect = 1'b0;
    @(negedge clk);
    check("t3_req_held", {31'b0, imem_req}, 32'd1);
    check("t3_valid", {31'b0, inst_valid}, 32'd0);
    tick(); tick(); imem_ack = 1'b1;
    tick(); @(negedge clk);
    check("t3_new_addr", imem_addr, 32'h0000_0100);
    check("t3_valid_after", {31'b0, inst_valid}, 32'd0);

    // Redirect coinciding with ack and pop
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0202;
    tick(); redirect = 1'b0;
    @(negedge clk);
    check("t4_valid", {31'b0, inst_valid}, 32'd0);
    check("t4_addr", imem_addr, 32'h0000_0200);
    check("t4_req", {31'b0, imem_req}, 32'd1);

    // Reset asserted mid-drain
    imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick(); redirect = 1'b0;
    @(negedge clk);
    check("t6_drain_req", {31'b0, imem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t6_idle_req", {31'b0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    check("t6_req", {31'b0, imem_req}, 32'd1);
    check("t6_addr", imem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      imem_ack    = ($urandom_range(0, 9) < 6);
      inst_ready  = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        check("rnd_rst_req", {31'b0, imem_req}, 32'd0);
        check("rnd_rst_valid", {31'b0, inst_valid}, 32'd0);
        #1 rst = 1'b0;
      end
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
